// File: rtl/cpu_trace_buffer.sv
// Retirement trace buffer: fill-and-stop or circular capture with PC trigger, then FIFO read-out.
// Optional per-record cycle stamp when TRACE_CYCLE_STAMP_EN is defined.
module cpu_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       mode,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       trc_valid,
    input  logic [XLEN-1:0]            trc_pc,
    input  logic [31:0]                trc_instr,
    input  logic                       trc_rd_we,
    input  logic [4:0]                 trc_rd_addr,
    input  logic [XLEN-1:0]            trc_rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_instr,
    output logic                       rd_rd_we,
    output logic [4:0]                 rd_rd_addr,
    output logic [XLEN-1:0]            rd_rd_data,
    output logic [31:0]                rd_cycle,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, DONE} state_t;

    state_t        state, state_d;
    logic          mode_q;
    logic [PW-1:0] wr_ptr, rd_ptr, post_cnt;
    logic          restart, wr_en, trig_hit, pop;

    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [31:0]     mem_instr[DEPTH];
    logic            mem_we   [DEPTH];
    logic [4:0]      mem_addr [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    assign busy     = (state == CAPTURE) || (state == POST);
    assign done     = (state == DONE);
    assign rd_valid = done && (count != '0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state;
        restart  = 1'b0;
        wr_en    = 1'b0;
        trig_hit = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    restart = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE, POST: begin
                if (arm) begin
                    restart = 1'b1;
                    state_d = CAPTURE;
                end else if (trc_valid) begin
                    wr_en = 1'b1;
                    if (state == POST) begin
                        if (post_cnt == PW'(1)) state_d = DONE;
                    end else if (!mode_q) begin
                        if (count == FULL - CW'(1)) state_d = DONE;
                    end else if (trc_pc == trig_pc) begin
                        trig_hit = 1'b1;
                        state_d  = (POST_TRIG == 0) ? DONE : POST;
                    end
                end
            end
            DONE: begin
                if (rd_valid && rd_ready) begin
                    pop = 1'b1;
                    if (count == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
        end else begin
            state <= state_d;
            if (restart) begin
                mode_q   <= mode;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                post_cnt <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                // A full circular buffer drops its oldest record to make room.
                if (count == FULL) begin
                    rd_ptr   <= rd_ptr + PW'(1);
                    overflow <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
                if (state == POST) post_cnt <= post_cnt - PW'(1);
                else if (trig_hit) post_cnt <= PW'(POST_TRIG);
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                count  <= count - CW'(1);
            end
        end
    end

    // NOTE: record storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= trc_pc;
            mem_instr[wr_ptr] <= trc_instr;
            mem_we[wr_ptr]    <= trc_rd_we;
            mem_addr[wr_ptr]  <= trc_rd_addr;
            mem_data[wr_ptr]  <= trc_rd_data;
        end
    end

    assign rd_pc      = mem_pc[rd_ptr];
    assign rd_instr   = mem_instr[rd_ptr];
    assign rd_rd_we   = mem_we[rd_ptr];
    assign rd_rd_addr = mem_addr[rd_ptr];
    assign rd_rd_data = mem_data[rd_ptr];

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc_cnt;
    logic [31:0] mem_cyc[DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_cnt <= '0;
        else      cyc_cnt <= cyc_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_cyc[wr_ptr] <= cyc_cnt;
    end

    assign rd_cycle = mem_cyc[rd_ptr];
`else
    assign rd_cycle = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: table-driven capture scenarios plus
// hand-written corner sequences, with a scoreboard queue for read-out order.
module tb_cpu_trace_buffer;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;
    localparam int CW        = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            arm = 1'b0;
    logic            mode = 1'b0;
    logic [XLEN-1:0] trig_pc = '0;
    logic            trc_valid = 1'b0;
    logic [XLEN-1:0] trc_pc = '0;
    logic [31:0]     trc_instr = '0;
    logic            trc_rd_we = 1'b0;
    logic [4:0]      trc_rd_addr = '0;
    logic [XLEN-1:0] trc_rd_data = '0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic            rd_rd_we;
    logic [4:0]      rd_rd_addr;
    logic [XLEN-1:0] rd_rd_data;
    logic [31:0]     rd_cycle;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            busy;
    logic            done;

    cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode), .trig_pc(trig_pc),
        .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_instr(trc_instr),
        .trc_rd_we(trc_rd_we), .trc_rd_addr(trc_rd_addr), .trc_rd_data(trc_rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_rd_we(rd_rd_we), .rd_rd_addr(rd_rd_addr), .rd_rd_data(rd_rd_data),
        .rd_cycle(rd_cycle), .count(count), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; equals the cycle stamp a write on the next edge gets.
    int tb_cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= 0;
        else      tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } rec_t;

    typedef struct {
        logic        mode;
        logic [31:0] trig;
        int          n_ret;
        int          exp_ret;
        int          exp_count;
        logic        exp_ovf;
        logic [31:0] first_pc;
    } vec_t;

    rec_t        sb[$];
    logic [31:0] stamp_of[256];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [XLEN-1:0] pc);
        rec_t r;
        r.pc    = pc;
        r.instr = pc ^ 32'h1357_9BDF;
        r.we    = pc[2];
        r.addr  = pc[6:2];
        r.data  = ~pc + 32'd7;
        return r;
    endfunction

    function automatic logic [31:0] exp_stamp(input logic [XLEN-1:0] pc);
`ifdef TRACE_CYCLE_STAMP_EN
        return stamp_of[pc[9:2]];
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        arm = 1'b0;
        trc_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic arm_cap(input logic m, input logic [31:0] tpc);
        arm = 1'b1;
        mode = m;
        trig_pc = tpc;
        tick();
        arm = 1'b0;
    endtask

    task automatic retire(input logic [XLEN-1:0] pc);
        rec_t r;
        r = mk(pc);
        trc_valid = 1'b1;
        trc_pc = r.pc;
        trc_instr = r.instr;
        trc_rd_we = r.we;
        trc_rd_addr = r.addr;
        trc_rd_data = r.data;
        stamp_of[pc[9:2]] = tb_cyc;
        tick();
    endtask

    task automatic push_range(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) sb.push_back(mk(first + 32'(4 * k)));
    endtask

    task automatic drain();
        int guard;
        rec_t e;
        guard = 0;
        rd_ready = 1'b1;
        while (sb.size() > 0 && guard < 2 * DEPTH) begin
            guard++;
            if (!rd_valid) begin
                check("drain_rd_valid", rd_valid, 1);
                break;
            end
            check("drain_count", count, sb.size());
            e = sb.pop_front();
            check("drain_pc", rd_pc, e.pc);
            check("drain_instr", rd_instr, e.instr);
            check("drain_we", rd_rd_we, e.we);
            check("drain_addr", rd_rd_addr, e.addr);
            check("drain_data", rd_rd_data, e.data);
            check("drain_cycle", rd_cycle, exp_stamp(e.pc));
            tick();
        end
        rd_ready = 1'b0;
        if (sb.size() != 0) begin
            check("drain_left", sb.size(), 0);
            sb.delete();
        end
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_rd_valid", rd_valid, 0);
        check("idle_count", count, 0);
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_FFF0, 20, 16, 16, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 32'h0000_0040, 28, 25, 16, 1'b1, 32'h24};
        vecs[2] = '{1'b1, 32'h0000_0008, 14, 11, 11, 1'b0, 32'h00};
        vecs[3] = '{1'b1, 32'h0000_003C, 26, 24, 16, 1'b1, 32'h20};
        vecs[4] = '{1'b0, 32'h0000_0008, 20, 16, 16, 1'b0, 32'h00};

        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);

        for (int v = 0; v < 5; v++) begin
            int got;
            do_reset();
            arm_cap(vecs[v].mode, vecs[v].trig);
            check("armed_busy", busy, 1);
            got = -1;
            for (int i = 0; i < vecs[v].n_ret; i++) begin
                retire(32'(4 * i));
                if (done && got < 0) got = i + 1;
            end
            trc_valid = 1'b0;
            check("retires_to_done", 32'(got), 32'(vecs[v].exp_ret));
            check("done_at_end", done, 1);
            check("count_at_done", count, vecs[v].exp_count);
            check("overflow_at_done", overflow, vecs[v].exp_ovf);
            check("rd_valid_at_done", rd_valid, 1);
            push_range(vecs[v].first_pc, vecs[v].exp_count);
            drain();
        end

        // Backpressure and arm-in-DONE.
        begin
            logic pat[4];
            pat = '{1'b1, 1'b0, 1'b0, 1'b1};
            do_reset();
            arm_cap(1'b0, 32'h0);
            for (int i = 0; i < 16; i++) retire(32'(4 * i));
            trc_valid = 1'b0;
            push_range(32'h0, 16);
            arm = 1'b1;
            tick();
            arm = 1'b0;
            check("arm_in_done_done", done, 1);
            check("arm_in_done_count", count, 16);
            for (int k = 0; k < 4; k++) begin
                rd_ready = pat[k];
                check("bp_pc", rd_pc, sb[0].pc);
                check("bp_data", rd_rd_data, sb[0].data);
                if (pat[k]) void'(sb.pop_front());
                tick();
            end
            rd_ready = 1'b0;
            check("bp_count", count, 14);
            drain();
        end

        // Arm with a simultaneous retire, then re-arm mid-capture.
        do_reset();
        arm = 1'b1;
        mode = 1'b0;
        trc_valid = 1'b1;
        trc_pc = 32'h10;
        tick();
        arm = 1'b0;
        trc_valid = 1'b0;
        check("arm_cycle_count", count, 0);
        check("arm_cycle_busy", busy, 1);
        for (int i = 0; i < 5; i++) retire(32'(4 * i));
        trc_valid = 1'b0;
        check("pre_rearm_count", count, 5);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_count", count, 0);
        check("rearm_busy", busy, 1);
        check("rearm_done", done, 0);

        // Asynchronous reset while in POST with a full buffer.
        do_reset();
        arm_cap(1'b1, 32'h40);
        for (int i = 0; i < 18; i++) retire(32'(4 * i));
        trc_valid = 1'b0;
        check("post_busy", busy, 1);
        check("post_count", count, 16);
        check("post_overflow", overflow, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_count", count, 0);
        check("async_overflow", overflow, 0);
        check("async_rd_valid", rd_valid, 0);

        // Cycle stamps for retires at cycles 10 and 13 after reset release.
        do_reset();
        arm_cap(1'b1, 32'h104);
        for (int g = 0; g < 20 && tb_cyc != 10; g++) tick();
        retire(32'h100);
        trc_valid = 1'b0;
        for (int g = 0; g < 20 && tb_cyc != 13; g++) tick();
        for (int i = 0; i < 9; i++) retire(32'h104 + 32'(4 * i));
        trc_valid = 1'b0;
        check("stamp_done", done, 1);
`ifdef TRACE_CYCLE_STAMP_EN
        check("stamp_first", rd_cycle, 32'd10);
`else
        check("stamp_first", rd_cycle, 32'd0);
`endif
        push_range(32'h100, 10);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameters, one per line:
- XLEN, 32, PC/data width.
- DEPTH, 16, record slots; power of 2, >=2.
- POST_TRIG, 8, records captured after trigger in circular mode; 0..DEPTH-1.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning); CW = $clog2(DEPTH+1):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  start/restart capture (pulse).
- mode  in  1  0 = fill-and-stop, 1 = circular with PC trigger.
- trig_pc  in  XLEN  trigger PC for mode 1.
- trc_valid  in  1  instruction retired this cycle.
- trc_pc  in  XLEN  retired PC.
- trc_instr  in  32  retired instruction word.
- trc_rd_we  in  1  register write occurred.
- trc_rd_addr  in  5  destination register.
- trc_rd_data  in  XLEN  write-back value.
- rd_valid  out  1  record available.
- rd_ready  in  1  consumer accepts record.
- rd_pc, rd_instr, rd_rd_we, rd_rd_addr, rd_rd_data  out  XLEN/32/1/5/XLEN  oldest record fields.
- rd_cycle  out  32  record cycle stamp.
- count  out  CW  records held.
- overflow  out  1  oldest records overwritten.
- busy  out  1  state is CAPTURE or POST.
- done  out  1  state is DONE.

Function
REQ-003 SHALL implement states IDLE, CAPTURE, POST, DONE.
REQ-004 IDLE: trc_* SHALL be ignored; arm=1 SHALL go to CAPTURE next edge, latch mode, clear pointers, count, overflow; a trc_valid in the arm cycle SHALL NOT be captured.
REQ-005 CAPTURE/POST: each trc_valid=1 cycle SHALL write one record {pc, instr, rd_we, rd_addr, rd_data, stamp} at the write pointer; write pointer SHALL wrap modulo DEPTH.
REQ-006 Mode 0: count SHALL increment per record; the record that makes count==DEPTH SHALL transition to DONE; no overwrite.
REQ-007 Mode 1: writes at count==DEPTH SHALL overwrite oldest, advance read pointer, hold count, set overflow (sticky until next arm).
REQ-008 Mode 1 CAPTURE: trc_valid with trc_pc==trig_pc SHALL write that record and go to POST with post counter=POST_TRIG, or to DONE if POST_TRIG==0.
REQ-009 POST: each captured record SHALL decrement the post counter; the record bringing it to 0 SHALL transition to DONE; trig_pc matches in POST SHALL be ignored.
REQ-010 arm=1 in CAPTURE/POST SHALL restart capture as REQ-004; arm in DONE SHALL be ignored.
REQ-011 DONE: rd_valid SHALL equal (count!=0); rd_* SHALL show the oldest record combinationally from storage, stable while rd_valid && !rd_ready; rd_valid && rd_ready SHALL pop one record (read pointer +1 mod DEPTH, count -1).
REQ-012 Popping the last record SHALL return to IDLE next edge with rd_valid=0; trc_* SHALL be ignored in DONE.
REQ-013 rd_valid SHALL be 0 outside DONE; rd_* values outside DONE are don't-care.
REQ-014 Read-out latency: DONE entry to rd_valid=1 SHALL be 0 cycles (same cycle done=1).

Reset
REQ-015 rst=0 SHALL asynchronously force IDLE, pointers=0, count=0, overflow=0, post counter=0, cycle counter=0; rd_valid, busy, done=0.
REQ-016 Reset mid-capture or mid-readout SHALL discard all records; storage contents need not be cleared.

Configuration
REQ-017 Macro TRACE_CYCLE_STAMP_EN defined: a free-running 32-bit cycle counter (increment every clk, wrap to 0) SHALL be stored per record and driven on rd_cycle.
REQ-018 Macro TRACE_CYCLE_STAMP_EN undefined: counter and stamp storage SHALL be omitted; rd_cycle SHALL be constant 0.

Verification
REQ-019 Mode 0, DEPTH=16: arm, 20 valid retires PC=0x00,0x04..0x4C -> DONE after 16th; drain with rd_ready=1 yields PC 0x00..0x3C in order, count 16->0, overflow=0, then IDLE.
REQ-020 Mode 1, trig_pc=0x40, POST_TRIG=8, PCs 0x00.. step 4 -> DONE after PC 0x60; 16 records PC 0x24..0x60; overflow=1.
REQ-021 Backpressure: DONE, rd_ready toggles 1,0,0,1 -> exactly 2 pops, rd_* held during stalls.
REQ-022 arm in same cycle as trc_valid (PC=0x10) from IDLE -> record not captured, count=0; arm during CAPTURE with count=5 -> count=0 next cycle.
REQ-023 rst=0 asserted in POST with count=16 -> immediately IDLE, count=0, overflow=0, rd_valid=0, without waiting for clk.
REQ-024 TRACE_CYCLE_STAMP_EN defined, retires at cycles 10 and 13 after reset release -> rd_cycle 10 then 13; undefined -> rd_cycle=0.
